// File: rtl/can_bit_timing.sv
// CAN bit-timing controller: tq prescaler, SYNC/SEG1/SEG2 sequencing,
// hard sync / resync on RX edges, and bus-idle integration.
module can_bit_timing #(
  parameter int SYNC_STAGES = 2,
  parameter int IDLE_BITS   = 11
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       can_rx,
  input  logic [5:0] brp,
  input  logic [3:0] tseg1,
  input  logic [2:0] tseg2,
  input  logic [1:0] sjw,
  output logic       sample,
  output logic       can_data,
  output logic       tx_point,
  output logic       bus_idle,
  output logic       hard_sync,
  output logic       resync
);
  typedef enum logic [1:0] {SYNC, SEG1, SEG2} state_t;
  localparam logic [3:0] IDLE_M1 = 4'(IDLE_BITS - 1);

  state_t state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic       rx_s, rx_d, sync_done;
  logic [5:0] pres, brp_q, brp_e;
  logic [3:0] tseg1_q, tseg1_e, idle_cnt;
  logic [2:0] tseg2_q, jmp;
  logic [1:0] sjw_q;
  logic [4:0] qcnt, len1, len2, len1_e, len2_e;
  logic [4:0] k1, add1, rem, rem2;
  logic       sync_start, tq_tick, edge_det;
  logic       do_hard, do_res;

  assign rx_s       = sync_q[SYNC_STAGES-1];
  assign sync_start = (state == SYNC) && (pres == 6'd0);
  // First clk of SYNC sees the live config it is latching.
  assign brp_e      = sync_start ? brp : brp_q;
  assign tseg1_e    = sync_start ? tseg1 : tseg1_q;
  assign tq_tick    = (pres == brp_e);

  assign edge_det = rx_d & ~rx_s & can_data & ~sync_done;
  assign do_hard  = edge_det & bus_idle;
  assign do_res   = edge_det & ~bus_idle & (state != SYNC);

  assign jmp  = (({1'b0, sjw_q} < tseg2_q) ?
                 {1'b0, sjw_q} : tseg2_q) + 3'd1;
  assign k1   = qcnt + 5'd1;
  assign add1 = (k1 < {2'b0, jmp}) ? k1 : {2'b0, jmp};
  assign rem  = {2'b0, tseg2_q} - qcnt;
  assign rem2 = (rem > {2'b0, jmp}) ?
                rem - {2'b0, jmp} : 5'd0;

  assign len1_e = (do_res && state == SEG1) ?
                  len1 + add1 : len1;
  assign len2_e = (do_res && state == SEG2) ?
                  k1 + rem2 : len2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SYNC;
      sync_q    <= '1;
      rx_d      <= 1'b1;
      pres      <= '0;
      qcnt      <= '0;
      len1      <= '0;
      len2      <= '0;
      brp_q     <= '0;
      tseg1_q   <= '0;
      tseg2_q   <= '0;
      sjw_q     <= '0;
      sync_done <= 1'b0;
      idle_cnt  <= '0;
      sample    <= 1'b0;
      can_data  <= 1'b1;
      tx_point  <= 1'b0;
      bus_idle  <= 1'b0;
      hard_sync <= 1'b0;
      resync    <= 1'b0;
    end else if (!en) begin
      state     <= SYNC;
      sync_q    <= '1;
      rx_d      <= 1'b1;
      pres      <= '0;
      qcnt      <= '0;
      len1      <= '0;
      len2      <= '0;
      brp_q     <= '0;
      tseg1_q   <= '0;
      tseg2_q   <= '0;
      sjw_q     <= '0;
      sync_done <= 1'b0;
      idle_cnt  <= '0;
      sample    <= 1'b0;
      can_data  <= 1'b1;
      tx_point  <= 1'b0;
      bus_idle  <= 1'b0;
      hard_sync <= 1'b0;
      resync    <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], can_rx};
      rx_d      <= rx_s;
      sample    <= 1'b0;
      tx_point  <= 1'b0;
      hard_sync <= 1'b0;
      resync    <= 1'b0;
      if (sync_start || do_hard) begin
        brp_q   <= brp;
        tseg1_q <= tseg1;
        tseg2_q <= tseg2;
        sjw_q   <= sjw;
      end
      if (do_hard) begin
        state     <= SYNC;
        pres      <= '0;
        qcnt      <= '0;
        sync_done <= 1'b1;
        hard_sync <= 1'b1;
      end else begin
        if (do_res) begin
          sync_done <= 1'b1;
          resync    <= 1'b1;
        end
        len1 <= len1_e;
        len2 <= len2_e;
        pres <= tq_tick ? 6'd0 : pres + 6'd1;
        if (tq_tick) begin
          unique case (state)
            SYNC: begin
              state <= SEG1;
              qcnt  <= '0;
              len1  <= {1'b0, tseg1_e} + 5'd1;
            end
            SEG1: begin
              if (qcnt == len1_e - 5'd1) begin
                state     <= SEG2;
                qcnt      <= '0;
                len2      <= {2'b0, tseg2_q} + 5'd1;
                sample    <= 1'b1;
                can_data  <= rx_s;
                sync_done <= 1'b0;
                if (rx_s) begin
                  if (idle_cnt != 4'hf)
                    idle_cnt <= idle_cnt + 4'd1;
                  if (idle_cnt >= IDLE_M1)
                    bus_idle <= 1'b1;
                end else begin
                  idle_cnt <= '0;
                  bus_idle <= 1'b0;
                end
              end else begin
                qcnt <= k1;
              end
            end
            SEG2: begin
              if (qcnt == len2_e - 5'd1) begin
                state    <= SYNC;
                qcnt     <= '0;
                tx_point <= 1'b1;
              end else begin
                qcnt <= k1;
              end
            end
            default: state <= SYNC;
          endcase
        end
      end
    end
  end
endmodule

// File: doc/can_bit_timing.md
# can_bit_timing

Bit-timing controller that sequences the CAN frame decoder. It divides the system clock into time quanta and synchronizes to edges on the raw CAN RX line. It produces the per-bit `sample` strobe and the sampled `can_data` value the decoder consumes, so the decoder no longer needs an externally generated bit strobe. It also tracks bus-idle integration (11 recessive bits), which gates hard synchronization.

## Interface
- `SYNC_STAGES`, 2, number of RX synchronizer flops (≥2).
- `IDLE_BITS`, 11, consecutive recessive sampled bits that declare the bus idle.

- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `en`  in  1  block enable. When 0: all state is held at reset values and outputs are at reset values.
- `can_rx`  in  1  raw CAN RX line (1 = recessive).
- `brp`  in  6  prescaler; one tq = brp+1 clk.
- `tseg1`  in  4  SEG1 length = tseg1+1 tq (propagation + phase1).
- `tseg2`  in  3  SEG2 length = tseg2+1 tq.
- `sjw`  in  2  resync jump width = sjw+1 tq; effective value min(sjw,tseg2)+1.
- `sample`  out  1  one-clk strobe, first clk of SEG2; drives decoder `sample`.
- `can_data`  out  1  bit value sampled at the SEG1/SEG2 boundary; valid with `sample` and held until the next `sample`.
- `tx_point`  out  1  one-clk strobe at the start of every SYNC segment.
- `bus_idle`  out  1  level; IDLE_BITS recessive samples seen since the last dominant sample.
- `hard_sync`  out  1  one-clk strobe when a hard sync is applied.
- `resync`  out  1  one-clk strobe when a resynchronization is applied.

## Operation
- **RX synchronizer.** `can_rx` passes through SYNC_STAGES flops (reset 1) to `rx_s`. `rx_d` = `rx_s` delayed by one clk.
- **Edge detection.** An edge exists when `rx_d`=1, `rx_s`=0, the last `can_data`=1, and `sync_done`=0.
- **sync_done flag.** Set on any hard sync or resync. Cleared on `sample`. This limits synchronization to at most one per bit.
- **Prescaler.** `pres` counts 0..brp_q. `tq_tick` fires when `pres`==brp_q.
- **Config latch.** brp/tseg1/tseg2/sjw are latched into `*_q` at each SYNC start and at each hard sync. Changes mid-bit do not affect the current bit.
- **FSM states.**
  - SYNC: 1 tq.
  - SEG1: `len1` tq, where `len1` = tseg1_q+1 plus any resync lengthening.
  - SEG2: `len2` tq, where `len2` = tseg2_q+1 minus any resync shortening.
  - `qcnt` counts tq within the current segment.
- **Transitions (on `tq_tick`).**
  - SYNC→SEG1.
  - SEG1→SEG2 when `qcnt`==len1-1. The sampled value is `rx_s` in that clk; `sample` and `can_data` update in the next clk.
  - SEG2→SYNC when `qcnt`==len2-1. `tx_point` pulses in the first clk of SYNC.
- **Hard sync** (edge while `bus_idle`=1): `pres`←0, state←SYNC, `qcnt`←0, config re-latched, `hard_sync` pulses. Hard sync overrides any other transition in the same clk.
- **Resync** (edge while `bus_idle`=0; effective jump j = min(sjw_q,tseg2_q)+1):
  - Edge in SYNC: no adjustment, `sync_done` is not set, no strobe.
  - Edge in SEG1 at tq index k: `len1` += min(k+1, j). `resync` pulses.
  - Edge in SEG2 at tq index k: remaining quanta after the current one, r = tseg2_q−k, becomes max(0, r−j). If the result is 0, SYNC starts at the next `tq_tick`. `resync` pulses.
- **Idle counter.** Saturating 4-bit count of consecutive recessive samples. `bus_idle`←1 when the count reaches IDLE_BITS. A dominant sample clears both the count and `bus_idle` in the `sample` clk. A hard sync does not clear `bus_idle`; the following dominant sample does.
- **Reset values.** state SYNC, `pres` 0, `qcnt` 0, `sync_done` 0, idle count 0. Outputs: `sample`/`tx_point`/`hard_sync`/`resync` = 0, `can_data` = 1, `bus_idle` = 0.

## Timing
- Nominal bit = (tseg1+tseg2+3)·(brp+1) clk. `sample` period equals the nominal bit absent resyncs.
- RX→edge latency: SYNC_STAGES clk from `can_rx` to `rx_s`. Edge acted on in the clk it is detected.
- After a hard sync in clk E, `sample` is asserted in clk E+(tseg1+2)(brp+1).
- All strobes are exactly one clk wide. `sample` and `tx_point` never coincide.
- Asynchronous reset mid-bit returns everything to reset values immediately. Counting resumes on the first clk with `rst_n`=1 and `en`=1.
- `en` falling mid-bit behaves as a synchronous clear to reset values.

## Test plan
1. **Idle integration.** brp=1, tseg1=5, tseg2=2, sjw=0, `can_rx`=1 → `sample` every 20 clk, `can_data`=1, `bus_idle` rises with the 11th `sample`.
2. **Hard sync.** From idle, `can_rx`→0 in clk T (SYNC_STAGES=2) → `hard_sync` at T+2, `sample` at T+16 with `can_data`=0, `bus_idle` falls the same clk.
3. **Late edge.** Not idle; recessive→dominant edge in SEG1 at k=2, sjw=1 → `len1`=8, `resync`=1, next `sample` 4 clk later than nominal.
4. **Early edge.** Edge in SEG2 at k=0, tseg2=2, sjw=3 (effective j=3) → SEG2 ends at the current tq, `tx_point` 4 clk early, only one `resync` per bit.
5. **Second edge ignored.** Two edges in the same bit → only the first causes `resync`; the second leaves timing unchanged.
6. **Reset and enable.** `rst_n` pulsed low mid-SEG1 → outputs return to reset values asynchronously, `bus_idle`=0, and re-integration needs 11 recessive samples. `en`=0 for 5 clk → no strobes during that window.
